regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the 32-entry integer register file in the pipelined RV32 core. It shares the register file's single write port between the in-order pipeline writeback stage and the long-latency multiply/divide unit. It buffers mul/div results in a 2-entry FIFO until a free write slot appears. It tracks destination registers with outstanding mul/div results so decode can stall on RAW/WAW hazards.

---
 rtl/regfile_wb_arbiter_if.sv | 43 ++++
 rtl/regfile_wb_arbiter.sv | 76 +++++++
 tb/tb_regfile_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the arbiter's pipeline-writeback, mul/div, register-file and decode-query signals.
// The master side drives requests; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned N = 32
);
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic [N-1:0] wb_data;
  logic         md_issue_valid;
  logic [4:0]   md_issue_rd;
  logic         md_valid;
  logic [4:0]   md_rd;
  logic [N-1:0] md_data;
  logic         md_ready;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [N-1:0] rf_wdata;
  logic [4:0]   query_rs1;
  logic [4:0]   query_rs2;
  logic         rs1_busy;
  logic         rs2_busy;
  logic         pending_any;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output md_issue_valid, md_issue_rd,
    output md_valid, md_rd, md_data,
    input  md_ready,
    input  rf_we, rf_waddr, rf_wdata,
    output query_rs1, query_rs2,
    input  rs1_busy, rs2_busy, pending_any
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  md_issue_valid, md_issue_rd,
    input  md_valid, md_rd, md_data,
    output md_ready,
    output rf_we, rf_waddr, rf_wdata,
    input  query_rs1, query_rs2,
    output rs1_busy, rs2_busy, pending_any
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback (absolute priority) and
// buffered mul/div results, and keeps a pending-destination scoreboard for decode stalls.
module regfile_wb_arbiter #(
  parameter int unsigned N = 32
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 5;
  localparam int unsigned REGS  = 32;
  localparam int unsigned CW    = 2;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [N-1:0]  data;
  } md_entry_t;

  md_entry_t         fifo_q [DEPTH];
  logic [CW-1:0]     count_q;
  logic              head_q;
  logic              tail_q;
  logic [REGS-1:0]   pending_q;
  logic [REGS-1:0]   pending_d;

  logic              wb_hit_c;
  logic              ready_c;
  logic              drain_c;
  logic              push_c;

  // Port arbitration, FIFO handshakes and next scoreboard value
  always_comb begin
    wb_hit_c  = 1'b0;
    ready_c   = 1'b0;
    drain_c   = 1'b0;
    push_c    = 1'b0;
    pending_d = pending_q;

    wb_hit_c = bus.wb_valid && (bus.wb_rd != '0);
    ready_c  = (count_q < CW'(DEPTH)) && !reset;
    drain_c  = !reset && !wb_hit_c && (count_q != '0);
    push_c   = bus.md_valid && ready_c && (bus.md_rd != '0);

    // Clear before set so a same-cycle reissue of the drained register stays pending
    if (drain_c) pending_d[fifo_q[head_q].rd] = 1'b0;
    if (bus.md_issue_valid && (bus.md_issue_rd != '0)) pending_d[bus.md_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      pending_q <= '0;
    end else begin
      if (push_c)  tail_q <= ~tail_q;
      if (drain_c) head_q <= ~head_q;
      count_q   <= count_q + CW'(push_c) - CW'(drain_c);
      pending_q <= pending_d;
    end
  end

  // Payload storage needs no reset; count_q qualifies every read
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[tail_q] <= '{rd: bus.md_rd, data: bus.md_data};
  end

  assign bus.md_ready    = ready_c;
  assign bus.rf_we       = !reset && (wb_hit_c || (count_q != '0));
  assign bus.rf_waddr    = wb_hit_c ? bus.wb_rd   : fifo_q[head_q].rd;
  assign bus.rf_wdata    = wb_hit_c ? bus.wb_data : fifo_q[head_q].data;
  assign bus.rs1_busy    = !reset && pending_q[bus.query_rs1];
  assign bus.rs2_busy    = !reset && pending_q[bus.query_rs2];
  assign bus.pending_any = !reset && ((|pending_q) || (count_q != '0));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter, checked against a queue-based
// model of the write-port arbitration and pending-register scoreboard.
module tb_regfile_wb_arbiter;
  localparam int unsigned N = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  regfile_wb_arbiter_if #(.N(N)) bus ();

  regfile_wb_arbiter #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [4:0]  rd;
    bit [31:0] data;
  } ent_t;

  ent_t      mq[$];
  bit [31:0] mpend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wb_valid       = 1'b0;
    bus.wb_rd          = '0;
    bus.wb_data        = '0;
    bus.md_issue_valid = 1'b0;
    bus.md_issue_rd    = '0;
    bus.md_valid       = 1'b0;
    bus.md_rd          = '0;
    bus.md_data        = '0;
  endtask

  // Mid-cycle: compare every output against the model's view of this cycle
  task automatic settle();
    bit hit;
    @(negedge clk);
    hit = bus.wb_valid && (bus.wb_rd != 0);
    if (reset) begin
      chk("rst_we", bus.rf_we, 0);
      chk("rst_ready", bus.md_ready, 0);
      chk("rst_busy1", bus.rs1_busy, 0);
      chk("rst_busy2", bus.rs2_busy, 0);
      chk("rst_pany", bus.pending_any, 0);
    end else begin
      chk("ready", bus.md_ready, 64'(mq.size() < 2));
      chk("busy1", bus.rs1_busy, 64'(bus.query_rs1 != 0 && mpend[bus.query_rs1]));
      chk("busy2", bus.rs2_busy, 64'(bus.query_rs2 != 0 && mpend[bus.query_rs2]));
      chk("pany", bus.pending_any, 64'(mpend != 0 || mq.size() != 0));
      if (hit) begin
        chk("we_wb", bus.rf_we, 1);
        chk("waddr_wb", bus.rf_waddr, 64'(bus.wb_rd));
        chk("wdata_wb", bus.rf_wdata, 64'(bus.wb_data));
      end else if (mq.size() > 0) begin
        chk("we_md", bus.rf_we, 1);
        chk("waddr_md", bus.rf_waddr, 64'(mq[0].rd));
        chk("wdata_md", bus.rf_wdata, 64'(mq[0].data));
      end else begin
        chk("we_idle", bus.rf_we, 0);
      end
    end
  endtask

  // Clock edge: advance the model with the inputs held during the cycle
  task automatic tick();
    bit hit;
    int sz;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      mpend = '0;
    end else begin
      hit = bus.wb_valid && (bus.wb_rd != 0);
      sz  = mq.size();
      if (!hit && sz > 0) begin
        mpend[mq[0].rd] = 1'b0;
        mq.delete(0);
      end
      if (bus.md_valid && sz < 2 && bus.md_rd != 0)
        mq.push_back('{rd: bus.md_rd, data: bus.md_data});
      if (bus.md_issue_valid && bus.md_issue_rd != 0) mpend[bus.md_issue_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mpend  = '0;
    idle();
    bus.query_rs1 = '0;
    bus.query_rs2 = '0;

    // Reset held two cycles with traffic on the inputs
    reset        = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h1111_1111;
    bus.md_valid = 1'b1; bus.md_rd = 5'd6; bus.md_data = 32'h2222_2222;
    bus.query_rs1 = 5'd6;
    repeat (2) cyc();
    reset = 1'b0;
    idle();
    settle();
    chk("rel_ready", bus.md_ready, 1);
    chk("rel_pany", bus.pending_any, 0);
    tick();

    // Pipeline pass-through, then x0 suppressed
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
    settle();
    chk("pass_we", bus.rf_we, 1);
    chk("pass_addr", bus.rf_waddr, 5);
    chk("pass_data", bus.rf_wdata, 64'h0000_0000_DEAD_BEEF);
    tick();
    bus.wb_rd = 5'd0;
    settle();
    chk("x0_we", bus.rf_we, 0);
    tick();
    idle();

    // Scoreboard lifecycle for x7
    bus.query_rs1 = 5'd7;
    bus.md_issue_valid = 1'b1; bus.md_issue_rd = 5'd7;
    cyc();
    bus.md_issue_valid = 1'b0;
    bus.md_valid = 1'b1; bus.md_rd = 5'd7; bus.md_data = 32'h1234;
    settle();
    chk("sb_busy_set", bus.rs1_busy, 1);
    chk("sb_accept", bus.md_ready, 1);
    tick();
    idle();
    settle();
    chk("sb_wr_we", bus.rf_we, 1);
    chk("sb_wr_addr", bus.rf_waddr, 7);
    chk("sb_wr_data", bus.rf_wdata, 64'h1234);
    tick();
    settle();
    chk("sb_busy_clr", bus.rs1_busy, 0);
    tick();

    // Back-pressure under continuous pipeline writes
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'hA5A5_0001;
    bus.md_valid = 1'b1; bus.md_rd = 5'd3; bus.md_data = 32'h0000_0333;
    cyc();
    bus.md_rd = 5'd4; bus.md_data = 32'h0000_0444;
    cyc();
    bus.md_rd = 5'd8; bus.md_data = 32'h0000_0888;
    settle();
    chk("bp_full", bus.md_ready, 0);
    tick();
    idle();
    settle();
    chk("bp_d1_addr", bus.rf_waddr, 3);
    tick();
    settle();
    chk("bp_d2_addr", bus.rf_waddr, 4);
    chk("bp_ready", bus.md_ready, 1);
    tick();

    // Push and pop together keep order
    bus.md_valid = 1'b1; bus.md_rd = 5'd10; bus.md_data = 32'hA;
    cyc();
    bus.md_rd = 5'd11; bus.md_data = 32'hB;
    settle();
    chk("pp_head", bus.rf_waddr, 10);
    tick();
    idle();
    settle();
    chk("pp_next", bus.rf_waddr, 11);
    tick();
    cyc();

    // Reissue of x9 in the cycle its older result drains keeps it pending
    bus.query_rs2 = 5'd9;
    bus.md_issue_valid = 1'b1; bus.md_issue_rd = 5'd9;
    cyc();
    idle();
    bus.md_valid = 1'b1; bus.md_rd = 5'd9; bus.md_data = 32'h99;
    cyc();
    idle();
    bus.md_issue_valid = 1'b1; bus.md_issue_rd = 5'd9;
    cyc();
    idle();
    settle();
    chk("set_wins", bus.rs2_busy, 1);
    tick();
    bus.md_valid = 1'b1; bus.md_rd = 5'd9; bus.md_data = 32'h98;
    cyc();
    idle();
    repeat (2) cyc();

    // Reset with a full FIFO and x3/x4 pending
    bus.md_issue_valid = 1'b1; bus.md_issue_rd = 5'd3;
    cyc();
    bus.md_issue_rd = 5'd4;
    cyc();
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h5;
    bus.md_valid = 1'b1; bus.md_rd = 5'd3; bus.md_data = 32'h33;
    cyc();
    bus.md_rd = 5'd4; bus.md_data = 32'h44;
    cyc();
    reset = 1'b1;
    settle();
    chk("mid_rst_we", bus.rf_we, 0);
    tick();
    reset = 1'b0;
    idle();
    settle();
    chk("post_rst_pany", bus.pending_any, 0);
    chk("post_rst_we", bus.rf_we, 0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset              = ($urandom_range(0, 99) < 2);
      bus.wb_valid       = $urandom_range(0, 1) == 1;
      bus.wb_rd          = 5'($urandom);
      bus.wb_data        = $urandom;
      bus.md_issue_valid = $urandom_range(0, 9) < 4;
      bus.md_issue_rd    = 5'($urandom);
      bus.md_valid       = $urandom_range(0, 9) < 6;
      bus.md_rd          = 5'($urandom);
      bus.md_data        = $urandom;
      bus.query_rs1      = 5'($urandom);
      bus.query_rs2      = 5'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
